// File: rtl/sd_dma_pkg.sv
// Shared types and register bit positions for the SD host DMA transfer path.
package sd_dma_pkg;

  // Transfer sequencing states.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StXfer    = 3'd1,
    StBlkEnd  = 3'd2,
    StGapStop = 3'd3,
    StDone    = 3'd4
  } dma_state_e;

  // Data direction as encoded in the Transfer Mode register.
  typedef enum logic {
    DirWrite = 1'b0,
    DirRead  = 1'b1
  } dma_dir_e;

  // Transfer Mode register bit positions.
  localparam int unsigned TmMultiBlkBit    = 5;
  localparam int unsigned TmDirBit         = 4;
  localparam int unsigned TmBlkCntEnBit    = 1;
  localparam int unsigned TmDmaEnBit       = 0;

  // Present State register bit positions.
  localparam int unsigned PsReadActiveBit  = 9;
  localparam int unsigned PsWriteActiveBit = 8;

  // Block Gap Control register bit positions.
  localparam int unsigned BgcStopBit       = 0;
  localparam int unsigned BgcContinueBit   = 1;

endpackage

// File: rtl/sd_dma_block_counter.sv
// Byte counter within one block; flags the beat that completes the block.
module sd_dma_block_counter
  import sd_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLKSZ_WIDTH = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   beat_i,
  input  logic [BLKSZ_WIDTH-1:0] blk_size_i,
  output logic                   blk_end_o
);

  localparam int unsigned BytesPerBeat = DATA_WIDTH / 8;

  logic [BLKSZ_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [BLKSZ_WIDTH:0]   byte_cnt_next;

  // One extra bit so the compare stays exact for the largest block size.
  assign byte_cnt_next = {1'b0, byte_cnt_q} + (BLKSZ_WIDTH + 1)'(BytesPerBeat);
  assign blk_end_o     = beat_i && (byte_cnt_next == {1'b0, blk_size_i});

  // Next byte count: clear wins, wrap to zero on the block-ending beat.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (clr_i) begin
      byte_cnt_d = '0;
    end else if (beat_i) begin
      if (blk_end_o) begin
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_next[BLKSZ_WIDTH-1:0];
      end
    end
  end

  // Byte count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: rtl/sd_dma_transfer_ctrl.sv
// Block-by-block data transfer sequencer fed by the decoded DMA registers.
// Runs the word/block counting, block gap stop/continue, and drives the
// transfer-active status and completion/gap/error pulses.
module sd_dma_transfer_ctrl
  import sd_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BLKCNT_WIDTH = 16,
  parameter int unsigned BLKSZ_WIDTH  = 12
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    Start,
  input  logic                    Abort,
  input  logic                    DMA_Enable,
  input  logic                    Block_Count_Enable,
  input  logic                    Data_Transfer_Direction_Select,
  input  logic                    Multi_Single_Block_Select,
  input  logic [BLKCNT_WIDTH-1:0] Block_Count,
  input  logic [BLKSZ_WIDTH-1:0]  Block_Size,
  input  logic                    Stop_At_Block_Gap_Request,
  input  logic                    Continue_Request,
  input  logic                    Data_Valid,
  output logic                    Data_Ready,
  output logic                    Read_Transfer_Active,
  output logic                    Write_Transfer_Active,
  output logic [BLKCNT_WIDTH-1:0] Blocks_Remaining,
  output logic                    Block_Gap_Event,
  output logic                    Transfer_Complete,
  output logic                    Start_Error
);

  dma_state_e state_q, state_d;

  // Shadow copies of the Transfer Mode / Block Size fields, frozen per transfer.
  dma_dir_e               dir_q, dir_d;
  logic                   multi_q, multi_d;
  logic                   bce_q, bce_d;
  logic [BLKSZ_WIDTH-1:0] blk_size_q, blk_size_d;

  logic [BLKCNT_WIDTH-1:0] blk_rem_q, blk_rem_d;
  logic                    active_q, active_d;
  logic                    gap_evt_q, gap_evt_d;
  logic                    cplt_q, cplt_d;
  logic                    start_err_q, start_err_d;

  logic                    beat;
  logic                    cnt_clr;
  logic                    blk_end;
  logic                    start_ok;
  logic                    last_blk;
  logic [BLKCNT_WIDTH-1:0] blk_rem_dec;

  assign Data_Ready = (state_q == StXfer);

  // A beat coinciding with Abort is dropped.
  assign beat     = Data_Ready && Data_Valid && !Abort;
  assign start_ok = (state_q == StIdle) && Start && DMA_Enable && !Abort;
  assign cnt_clr  = Abort || start_ok;

  assign blk_rem_dec = (blk_rem_q == '0) ? '0 : (blk_rem_q - BLKCNT_WIDTH'(1));
  assign last_blk    = !multi_q || (bce_q && (blk_rem_dec == '0));

  sd_dma_block_counter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BLKSZ_WIDTH (BLKSZ_WIDTH)
  ) u_block_counter (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .clr_i      (cnt_clr),
    .beat_i     (beat),
    .blk_size_i (blk_size_q),
    .blk_end_o  (blk_end)
  );

  // Next-state, shadow capture and registered pulse generation.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    multi_d     = multi_q;
    bce_d       = bce_q;
    blk_size_d  = blk_size_q;
    blk_rem_d   = blk_rem_q;
    active_d    = active_q;
    gap_evt_d   = 1'b0;
    cplt_d      = 1'b0;
    start_err_d = 1'b0;

    if (Abort) begin
      // Blocks_Remaining intentionally keeps its value for software read-back.
      state_d  = StIdle;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            if (!DMA_Enable) begin
              start_err_d = 1'b1;
            end else begin
              dir_d      = dma_dir_e'(Data_Transfer_Direction_Select);
              multi_d    = Multi_Single_Block_Select;
              bce_d      = Block_Count_Enable;
              blk_size_d = Block_Size;
              blk_rem_d  = Block_Count;
              if (Multi_Single_Block_Select && Block_Count_Enable && (Block_Count == '0)) begin
                // Nothing to move: complete without ever going active.
                state_d = StDone;
                cplt_d  = 1'b1;
              end else begin
                state_d  = StXfer;
                active_d = 1'b1;
              end
            end
          end
        end

        StXfer: begin
          if (blk_end) begin
            state_d = StBlkEnd;
          end
        end

        StBlkEnd: begin
          if (bce_q) begin
            blk_rem_d = blk_rem_dec;
          end
          if (last_blk) begin
            state_d = StDone;
            cplt_d  = 1'b1;
          end else if (Stop_At_Block_Gap_Request) begin
            state_d   = StGapStop;
            gap_evt_d = 1'b1;
            active_d  = 1'b0;
          end else begin
            state_d = StXfer;
          end
        end

        StGapStop: begin
          if (Continue_Request && !Stop_At_Block_Gap_Request) begin
            state_d  = StXfer;
            active_d = 1'b1;
          end
        end

        StDone: begin
          state_d  = StIdle;
          active_d = 1'b0;
        end

        default: begin
          state_d  = StIdle;
          active_d = 1'b0;
        end
      endcase
    end
  end

  // State, shadow and status registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      dir_q       <= DirWrite;
      multi_q     <= 1'b0;
      bce_q       <= 1'b0;
      blk_size_q  <= '0;
      blk_rem_q   <= '0;
      active_q    <= 1'b0;
      gap_evt_q   <= 1'b0;
      cplt_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      multi_q     <= multi_d;
      bce_q       <= bce_d;
      blk_size_q  <= blk_size_d;
      blk_rem_q   <= blk_rem_d;
      active_q    <= active_d;
      gap_evt_q   <= gap_evt_d;
      cplt_q      <= cplt_d;
      start_err_q <= start_err_d;
    end
  end

  assign Read_Transfer_Active  = active_q && (dir_q == DirRead);
  assign Write_Transfer_Active = active_q && (dir_q == DirWrite);
  assign Blocks_Remaining      = blk_rem_q;
  assign Block_Gap_Event       = gap_evt_q;
  assign Transfer_Complete     = cplt_q;
  assign Start_Error           = start_err_q;

endmodule

// File: tb/tb_sd_dma_transfer_ctrl.sv
// Directed bench for sd_dma_transfer_ctrl: a vector table for short transfers
// plus hand sequences for long blocks, gap stop, abort and async reset.
module tb_sd_dma_transfer_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        Start, Abort, DMA_Enable, Block_Count_Enable;
  logic        Data_Transfer_Direction_Select, Multi_Single_Block_Select;
  logic [15:0] Block_Count;
  logic [11:0] Block_Size;
  logic        Stop_At_Block_Gap_Request, Continue_Request, Data_Valid;
  logic        Data_Ready, Read_Transfer_Active, Write_Transfer_Active;
  logic [15:0] Blocks_Remaining;
  logic        Block_Gap_Event, Transfer_Complete, Start_Error;

  int errors = 0;
  int checks = 0;

  sd_dma_transfer_ctrl #(
    .DATA_WIDTH   (32),
    .BLKCNT_WIDTH (16),
    .BLKSZ_WIDTH  (12)
  ) dut (
    .CLK                            (CLK),
    .RESET_N                        (RESET_N),
    .Start                          (Start),
    .Abort                          (Abort),
    .DMA_Enable                     (DMA_Enable),
    .Block_Count_Enable             (Block_Count_Enable),
    .Data_Transfer_Direction_Select (Data_Transfer_Direction_Select),
    .Multi_Single_Block_Select      (Multi_Single_Block_Select),
    .Block_Count                    (Block_Count),
    .Block_Size                     (Block_Size),
    .Stop_At_Block_Gap_Request      (Stop_At_Block_Gap_Request),
    .Continue_Request               (Continue_Request),
    .Data_Valid                     (Data_Valid),
    .Data_Ready                     (Data_Ready),
    .Read_Transfer_Active           (Read_Transfer_Active),
    .Write_Transfer_Active          (Write_Transfer_Active),
    .Blocks_Remaining               (Blocks_Remaining),
    .Block_Gap_Event                (Block_Gap_Event),
    .Transfer_Complete              (Transfer_Complete),
    .Start_Error                    (Start_Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int start, dma, bce, dir, multi, bcnt, bsize, stop, cont, valid, abort;
    int rdy, rd, wr, rem, gap, cplt, err;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Start = 0; Abort = 0; DMA_Enable = 0; Block_Count_Enable = 0;
    Data_Transfer_Direction_Select = 0; Multi_Single_Block_Select = 0;
    Block_Count = 0; Block_Size = 12'd8; Stop_At_Block_Gap_Request = 0;
    Continue_Request = 0; Data_Valid = 0;
  endtask

  // Called just after a negedge; returns at the next negedge with Start low.
  task automatic do_start(input logic dir, input logic multi, input logic bce,
                          input logic [15:0] bcnt, input logic [11:0] bsize);
    Start = 1; DMA_Enable = 1; Data_Transfer_Direction_Select = dir;
    Multi_Single_Block_Select = multi; Block_Count_Enable = bce;
    Block_Count = bcnt; Block_Size = bsize;
    @(negedge CLK);
    Start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, beats2, wr_cyc, ncplt, cidx, last_beat, extra, gap_seen, rd_seen, wr_seen, done;
    logic [15:0] rems[$];

    // start dma bce dir multi bcnt bsize stop cont valid abort | rdy rd wr rem gap cplt err
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 1, 0, 1, 0, 8, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 1, 0, 0, 5, 8, 0, 0, 0, 0,   1, 0, 1, 5, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   1, 0, 1, 5, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   0, 0, 1, 5, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   0, 0, 1, 4, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 0, 4, 0, 0, 0};
    vecs[9]  = '{1, 1, 1, 1, 1, 2, 8, 0, 0, 0, 0,   1, 1, 0, 2, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0,   1, 1, 0, 2, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0,   0, 1, 0, 2, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   1, 1, 0, 1, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   1, 1, 0, 1, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   0, 1, 0, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 1, 0, 0, 0, 7, 8, 0, 0, 0, 0,   1, 0, 1, 7, 0, 0, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   1, 0, 1, 7, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 1,   0, 0, 0, 7, 0, 0, 0};
    vecs[20] = '{1, 1, 0, 0, 0, 7, 8, 0, 0, 0, 0,   1, 0, 1, 7, 0, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   1, 0, 1, 7, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0,   0, 0, 1, 7, 0, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 1, 7, 0, 1, 0};
    vecs[24] = '{0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0,   0, 0, 0, 7, 0, 0, 0};

    // Reset state.
    clear_inputs();
    RESET_N = 0;
    repeat (2) @(negedge CLK);
    chk("reset.ready", 32'(Data_Ready), 0);
    chk("reset.rd", 32'(Read_Transfer_Active), 0);
    chk("reset.wr", 32'(Write_Transfer_Active), 0);
    chk("reset.rem", 32'(Blocks_Remaining), 0);
    chk("reset.pulses", 32'({Block_Gap_Event, Transfer_Complete, Start_Error}), 0);
    RESET_N = 1;
    @(negedge CLK);

    // Vector table: inputs applied after a negedge, outputs checked one edge later.
    for (int i = 0; i < 25; i++) begin
      Start = vecs[i].start[0]; DMA_Enable = vecs[i].dma[0];
      Block_Count_Enable = vecs[i].bce[0]; Data_Transfer_Direction_Select = vecs[i].dir[0];
      Multi_Single_Block_Select = vecs[i].multi[0]; Block_Count = vecs[i].bcnt[15:0];
      Block_Size = vecs[i].bsize[11:0]; Stop_At_Block_Gap_Request = vecs[i].stop[0];
      Continue_Request = vecs[i].cont[0]; Data_Valid = vecs[i].valid[0];
      Abort = vecs[i].abort[0];
      @(negedge CLK);
      chk($sformatf("vec%0d.ready", i), 32'(Data_Ready), vecs[i].rdy);
      chk($sformatf("vec%0d.rd", i), 32'(Read_Transfer_Active), vecs[i].rd);
      chk($sformatf("vec%0d.wr", i), 32'(Write_Transfer_Active), vecs[i].wr);
      chk($sformatf("vec%0d.rem", i), 32'(Blocks_Remaining), vecs[i].rem);
      chk($sformatf("vec%0d.gap", i), 32'(Block_Gap_Event), vecs[i].gap);
      chk($sformatf("vec%0d.cplt", i), 32'(Transfer_Complete), vecs[i].cplt);
      chk($sformatf("vec%0d.err", i), 32'(Start_Error), vecs[i].err);
    end
    clear_inputs();
    @(negedge CLK);

    // Single 512-byte write block with Data_Valid held high.
    do_start(1'b0, 1'b0, 1'b0, 16'd1, 12'd512);
    Data_Valid = 1;
    beats = 0; wr_cyc = 0; ncplt = 0; cidx = -1; rd_seen = 0;
    for (int i = 0; i < 140; i++) begin
      if (Data_Ready) beats++;
      if (Write_Transfer_Active) wr_cyc++;
      if (Read_Transfer_Active) rd_seen = 1;
      if (Transfer_Complete) begin ncplt++; cidx = i; end
      @(negedge CLK);
    end
    chk("single.beats", beats, 128);
    chk("single.wr_cycles", wr_cyc, 130);
    chk("single.cplt_count", ncplt, 1);
    chk("single.cplt_cycle", cidx, 129);
    chk("single.rd_seen", rd_seen, 0);
    clear_inputs();
    @(negedge CLK);

    // Counted multi-block read: 3 blocks of 64 bytes.
    do_start(1'b1, 1'b1, 1'b1, 16'd3, 12'd64);
    Data_Valid = 1;
    beats = 0; ncplt = 0; cidx = -1; last_beat = -1; wr_seen = 0;
    rems.delete();
    for (int i = 0; i < 80; i++) begin
      if (rems.size() == 0 || rems[rems.size() - 1] != Blocks_Remaining)
        rems.push_back(Blocks_Remaining);
      if (Data_Ready) begin beats++; last_beat = i; end
      if (Write_Transfer_Active) wr_seen = 1;
      if (Transfer_Complete) begin ncplt++; cidx = i; end
      @(negedge CLK);
    end
    chk("multi.beats", beats, 48);
    chk("multi.cplt_count", ncplt, 1);
    chk("multi.cplt_after_last_beat", cidx - last_beat, 2);
    chk("multi.wr_seen", wr_seen, 0);
    chk("multi.rem_steps", rems.size(), 4);
    for (int k = 0; k < 4 && k < rems.size(); k++)
      chk($sformatf("multi.rem_step%0d", k), 32'(rems[k]), 3 - k);
    clear_inputs();
    @(negedge CLK);

    // Gap stop after block 2 of 4, then continue.
    do_start(1'b0, 1'b1, 1'b1, 16'd4, 12'd16);
    Data_Valid = 1;
    beats = 0; gap_seen = 0;
    for (int i = 0; i < 100 && gap_seen == 0; i++) begin
      if (Block_Gap_Event) begin
        gap_seen = 1;
      end else begin
        if (Data_Ready) beats++;
        if (beats >= 6) Stop_At_Block_Gap_Request = 1;
        @(negedge CLK);
      end
    end
    chk("gap.event_seen", gap_seen, 1);
    chk("gap.beats_before", beats, 8);
    chk("gap.rem", 32'(Blocks_Remaining), 2);
    chk("gap.ready", 32'(Data_Ready), 0);
    chk("gap.wr", 32'(Write_Transfer_Active), 0);
    @(negedge CLK);
    chk("gap.event_one_cycle", 32'(Block_Gap_Event), 0);
    Continue_Request = 1;
    @(negedge CLK);
    Continue_Request = 0;
    @(negedge CLK);
    chk("gap.continue_while_stop", 32'(Data_Ready), 0);
    chk("gap.rem_held", 32'(Blocks_Remaining), 2);
    Stop_At_Block_Gap_Request = 0;
    @(negedge CLK);
    chk("gap.stop_clear_only", 32'(Data_Ready), 0);
    Continue_Request = 1;
    @(negedge CLK);
    Continue_Request = 0;
    chk("gap.resume_ready", 32'(Data_Ready), 1);
    chk("gap.resume_wr", 32'(Write_Transfer_Active), 1);
    beats2 = 0; extra = 0; done = 0;
    for (int i = 0; i < 60 && done == 0; i++) begin
      if (Transfer_Complete) begin
        done = 1;
        chk("gap.rem_final", 32'(Blocks_Remaining), 0);
      end else begin
        if (Data_Ready) beats2++;
        if (Block_Gap_Event) extra++;
        @(negedge CLK);
      end
    end
    chk("gap.completed", done, 1);
    chk("gap.beats_after", beats2, 8);
    chk("gap.extra_events", extra, 0);
    clear_inputs();
    @(negedge CLK);

    // Abort after 10 beats of a 512-byte block.
    do_start(1'b0, 1'b0, 1'b0, 16'd1, 12'd512);
    Data_Valid = 1;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      if (Data_Ready) beats++;
      @(negedge CLK);
    end
    chk("abort.beats", beats, 10);
    Abort = 1;
    @(negedge CLK);
    Abort = 0;
    chk("abort.ready", 32'(Data_Ready), 0);
    chk("abort.wr", 32'(Write_Transfer_Active), 0);
    ncplt = 0; beats = 0;
    for (int i = 0; i < 6; i++) begin
      if (Transfer_Complete) ncplt++;
      if (Data_Ready) beats++;
      @(negedge CLK);
    end
    chk("abort.no_cplt", ncplt, 0);
    chk("abort.stays_idle", beats, 0);
    clear_inputs();
    @(negedge CLK);

    // Asynchronous reset mid-block, then a fresh full block.
    do_start(1'b0, 1'b0, 1'b0, 16'd9, 12'd512);
    Data_Valid = 1;
    repeat (20) @(negedge CLK);
    chk("areset.pre_wr", 32'(Write_Transfer_Active), 1);
    chk("areset.pre_rem", 32'(Blocks_Remaining), 9);
    #2 RESET_N = 0;
    #1;
    chk("areset.ready", 32'(Data_Ready), 0);
    chk("areset.wr", 32'(Write_Transfer_Active), 0);
    chk("areset.rd", 32'(Read_Transfer_Active), 0);
    chk("areset.rem", 32'(Blocks_Remaining), 0);
    chk("areset.pulses", 32'({Block_Gap_Event, Transfer_Complete, Start_Error}), 0);
    @(negedge CLK);
    RESET_N = 1;
    clear_inputs();
    @(negedge CLK);
    do_start(1'b0, 1'b0, 1'b0, 16'd1, 12'd512);
    Data_Valid = 1;
    beats = 0; done = 0;
    for (int i = 0; i < 200 && done == 0; i++) begin
      if (Transfer_Complete) done = 1;
      else begin
        if (Data_Ready) beats++;
        @(negedge CLK);
      end
    end
    chk("areset.new_completed", done, 1);
    chk("areset.new_beats", beats, 128);
    clear_inputs();
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
